seq_alu: RTL and testbench

- Parametrised, handshaked, multi-cycle successor to the single-cycle 16-bit datapath ALU.
- Arithmetic and logic ops complete in one cycle.
- Shifts and rotates run iteratively, one bit position per cycle, replacing the combinational barrel shifter.
- Sits between the decode/register-read stage and writeback; the pipeline control uses in_ready/out_valid to stall.

---
 rtl/seq_alu.sv | 184 ++++++++++++++++++
 tb/tb_seq_alu.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: handshaked multi-cycle ALU. Add/logic ops finish in one cycle;
// shifts and rotates step one bit position per cycle.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready          request handshake (ready only in IDLE)
//   A, B, Cin, Op              operands, carry-in, op select
//   invA, invB, sign           operand inversion, signed overflow mode
//   out_valid/out_ready        result handshake
//   Out, Ofl, Z, N, P          result and flags, held while out_valid
module seq_alu #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [2:0]       Op,
    input  logic             invA,
    input  logic             invB,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             Ofl,
    output logic             Z,
    output logic             N,
    output logic             P
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } stateT;

    stateT state;
    stateT nextState;

    logic [WIDTH-1:0]   opA;
    logic [WIDTH-1:0]   opB;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   aluRes;
    logic               aluOfl;
    logic               accept;

    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   shifted;
    logic [SHAMT_W-1:0] count;
    logic [1:0]         shOp;

    logic               writeRes;
    logic [WIDTH-1:0]   resNext;
    logic               oflNext;

    assign opA    = invA ? ~A : A;
    assign opB    = invB ? ~B : B;
    assign shamt  = opB[SHAMT_W-1:0];
    assign accept = in_valid & in_ready;
    assign sum    = {1'b0, opA} + {1'b0, opB} + {{WIDTH{1'b0}}, Cin};

    // Single-cycle ops, evaluated on the raw inputs at the accept edge.
    always_comb begin
        aluRes = sum[WIDTH-1:0];
        aluOfl = 1'b0;
        unique case (Op[1:0])
            2'b00: begin
                aluRes = sum[WIDTH-1:0];
                // Signed: like-signed operands producing an opposite-signed sum.
                aluOfl = sign
                    ? ((opA[WIDTH-1] == opB[WIDTH-1]) &&
                       (sum[WIDTH-1] != opA[WIDTH-1]))
                    : sum[WIDTH];
            end
            2'b01: aluRes = opA | opB;
            2'b10: aluRes = opA ^ opB;
            2'b11: aluRes = opA & opB;
        endcase
    end

    // One-position step of the working register.
    always_comb begin
        shifted = work;
        unique case (shOp)
            2'b00: shifted = {work[WIDTH-2:0], work[WIDTH-1]};
            2'b01: shifted = {work[WIDTH-2:0], 1'b0};
            2'b10: shifted = {work[WIDTH-1], work[WIDTH-1:1]};
            2'b11: shifted = {1'b0, work[WIDTH-1:1]};
        endcase
    end

    // Result writeback select: ALU or zero-count shift at accept,
    // or the last shift step.
    always_comb begin
        writeRes = 1'b0;
        resNext  = aluRes;
        oflNext  = 1'b0;
        if (accept) begin
            if (Op[2]) begin
                writeRes = 1'b1;
                resNext  = aluRes;
                oflNext  = aluOfl;
            end else if (shamt == '0) begin
                writeRes = 1'b1;
                resNext  = opA;
            end
        end else if (state == SHIFT && count == SHAMT_W'(1)) begin
            writeRes = 1'b1;
            resNext  = shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = ~rst;
                if (accept) begin
                    if (Op[2] || shamt == '0) begin
                        nextState = DONE;
                    end else begin
                        nextState = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (count == SHAMT_W'(1)) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work  <= '0;
            count <= '0;
            shOp  <= 2'b00;
            Out   <= '0;
            Ofl   <= 1'b0;
            Z     <= 1'b0;
            N     <= 1'b0;
            P     <= 1'b0;
        end else begin
            if (accept && !Op[2]) begin
                work  <= opA;
                count <= shamt;
                shOp  <= Op[1:0];
            end else if (state == SHIFT) begin
                work  <= shifted;
                count <= count - SHAMT_W'(1);
            end
            if (writeRes) begin
                Out <= resNext;
                Ofl <= oflNext;
                Z   <= (resNext == '0);
                N   <= resNext[WIDTH-1];
                P   <= (resNext != '0) & ~resNext[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed-vector bench for seq_alu (WIDTH=16).
// Expected values are hand-computed constants.
module tb_seq_alu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic [2:0]  Op;
    logic        invA;
    logic        invB;
    logic        sign;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Out;
    logic        Ofl;
    logic        Z;
    logic        N;
    logic        P;

    int checks = 0;
    int errors = 0;
    int lat;
    int stall;

    seq_alu #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Op        (Op),
        .invA      (invA),
        .invB      (invB),
        .sign      (sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Out       (Out),
        .Ofl       (Ofl),
        .Z         (Z),
        .N         (N),
        .P         (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a request at a negedge; it is accepted at the next posedge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic [2:0] op,
                         input logic ia, input logic ib, input logic sg);
        @(negedge clk);
        A = a; B = b; Cin = c; Op = op;
        invA = ia; invB = ib; sign = sg;
        in_valid = 1'b1;
        check("issueReady", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Cycles from the accept edge until out_valid, and stalled cycles seen.
    task automatic waitOut(output int l, output int s);
        l = 0;
        s = 0;
        do begin
            @(negedge clk);
            l++;
            if (!out_valid && !in_ready) s++;
        end while (!out_valid && l < 40);
    endtask

    task automatic drain;
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drainValid", out_valid, 0);
        check("drainReady", in_ready, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Cin = 1'b0; Op = 3'b000;
        invA = 1'b0; invB = 1'b0; sign = 1'b0;
        repeat (2) @(negedge clk);
        check("rstReady", in_ready, 0);
        check("rstValid", out_valid, 0);
        check("rstOut", Out, 16'h0000);
        check("rstP", P, 0);
        check("rstZ", Z, 0);
        rst = 1'b0;
        #1 check("postRstReady", in_ready, 1);

        // 1: unsigned wrap
        issue(16'hFFFF, 16'h0001, 0, 3'b100, 0, 0, 0);
        waitOut(lat, stall);
        check("t1Lat", lat, 1);
        check("t1Out", Out, 16'h0000);
        check("t1Ofl", Ofl, 1);
        check("t1ZNP", {Z, N, P}, 3'b100);
        drain();

        // 2: signed subtract overflow
        issue(16'h8000, 16'h0001, 1, 3'b100, 0, 1, 1);
        waitOut(lat, stall);
        check("t2Out", Out, 16'h7FFF);
        check("t2Ofl", Ofl, 1);
        check("t2P", P, 1);
        drain();

        // extra: XOR and AND, unsigned add without carry
        issue(16'h00FF, 16'h0F0F, 0, 3'b110, 0, 0, 0);
        waitOut(lat, stall);
        check("xorOut", Out, 16'h0FF0);
        drain();
        issue(16'hF0F0, 16'h8F00, 0, 3'b111, 0, 0, 0);
        waitOut(lat, stall);
        check("andOut", Out, 16'h8000);
        check("andN", N, 1);
        drain();
        issue(16'h1234, 16'h1111, 1, 3'b100, 0, 0, 0);
        waitOut(lat, stall);
        check("addOut", Out, 16'h2346);
        check("addOfl", Ofl, 0);
        drain();

        // 3: rotate left by 4
        issue(16'h8001, 16'h0004, 0, 3'b000, 0, 0, 0);
        waitOut(lat, stall);
        check("t3Stall", stall, 4);
        check("t3Lat", lat, 5);
        check("t3Out", Out, 16'h0018);
        check("t3Ofl", Ofl, 0);
        drain();

        // 4: SRA / SRL by 15
        issue(16'h8000, 16'h000F, 0, 3'b010, 0, 0, 0);
        waitOut(lat, stall);
        check("t4Lat", lat, 16);
        check("t4SraOut", Out, 16'hFFFF);
        check("t4SraN", N, 1);
        drain();
        issue(16'h8000, 16'h000F, 0, 3'b011, 0, 0, 0);
        waitOut(lat, stall);
        check("t4SrlOut", Out, 16'h0001);
        drain();

        // extra: SLL by 3, upper count bits ignored
        issue(16'h0811, 16'hFFF3, 0, 3'b001, 0, 0, 0);
        waitOut(lat, stall);
        check("sllLat", lat, 4);
        check("sllOut", Out, 16'h4088);
        drain();

        // 5: zero count with backpressure
        issue(16'h1234, 16'h0000, 0, 3'b001, 0, 0, 0);
        waitOut(lat, stall);
        check("t5Lat", lat, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5Hold", {out_valid, Out}, {1'b1, 16'h1234});
        end
        A = 16'hAAAA; B = 16'h5555; Op = 3'b101;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("t5Valid", out_valid, 0);
        check("t5Ready", in_ready, 1);
        @(negedge clk);
        check("t5Ignored", {out_valid, Out}, {1'b0, 16'h1234});

        // 6: reset mid-shift
        issue(16'hFFFF, 16'h000A, 0, 3'b011, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6Valid", out_valid, 0);
        check("t6Out", Out, 16'h0000);
        check("t6RstReady", in_ready, 0);
        rst = 1'b0;
        #1 check("t6Ready", in_ready, 1);
        issue(16'h00F0, 16'h0F00, 0, 3'b101, 0, 0, 0);
        waitOut(lat, stall);
        check("t6OrLat", lat, 1);
        check("t6OrOut", Out, 16'h0FF0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
